// File: rtl/mean_pkg.sv
// Shared constants and helpers for the meanN streaming front ends.
package mean_pkg;

  localparam int MEAN8_N   = 8;
  localparam int MEAN8_LAT = 4;
  localparam int FILL_W    = 4;
  localparam int PHASE_W   = 3;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(MEAN8_N);

  typedef enum logic {
    MODE_SLIDING = 1'b0,
    MODE_BLOCK   = 1'b1
  } win_mode_e;

  // Window occupancy after one more sample, saturating once the window is full.
  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    return (f >= FILL_FULL) ? FILL_FULL : f + FILL_W'(1);
  endfunction

endpackage

// File: rtl/vld_delay.sv
// Single-bit delay line used to align a window qualifier with a fixed-latency
// averager; clr wipes every stage so stale qualifiers never escape.
module vld_delay #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] line_q;
  logic [DEPTH-1:0] line_d;

  always_comb begin
    line_d    = line_q << 1;
    line_d[0] = d;
    if (clr) begin
      line_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign q = line_q[DEPTH-1];

endmodule

// File: rtl/mean8_window.sv
// Eight-tap sample window feeding mean8, with window and result qualifiers
// for sliding (every sample) or block (every eighth sample) averaging.
module mean8_window
  import mean_pkg::*;
#(
  parameter int WID = 16,
  parameter int LAT = MEAN8_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [WID-1:0]    s_data,
  input  logic              mode,
  input  logic              flush,
  output logic [WID-1:0]    tap_000,
  output logic [WID-1:0]    tap_001,
  output logic [WID-1:0]    tap_002,
  output logic [WID-1:0]    tap_003,
  output logic [WID-1:0]    tap_004,
  output logic [WID-1:0]    tap_005,
  output logic [WID-1:0]    tap_006,
  output logic [WID-1:0]    tap_007,
  output logic              win_valid,
  output logic              mean_valid,
  output logic [FILL_W-1:0] fill
);

  logic [MEAN8_N-1:0][WID-1:0] taps_q, taps_d;
  logic [FILL_W-1:0]           fill_q, fill_d;
  logic [PHASE_W-1:0]          phase_q, phase_d;
  logic                        win_valid_q, win_valid_d;
  logic                        accept;
  logic [FILL_W-1:0]           fill_nx;

  // Phase only advances once the window is full, so phase 0 marks the accept
  // that completes a block: the 8th sample, then every 8th after it.
  always_comb begin
    accept      = s_valid & ~flush;
    fill_nx     = fill_inc(fill_q);
    taps_d      = taps_q;
    fill_d      = fill_q;
    phase_d     = phase_q;
    win_valid_d = 1'b0;
    if (flush) begin
      taps_d  = '0;
      fill_d  = '0;
      phase_d = '0;
    end else if (accept) begin
      taps_d = {taps_q[MEAN8_N-2:0], s_data};
      fill_d = fill_nx;
      if (fill_nx == FILL_FULL) begin
        phase_d     = phase_q + PHASE_W'(1);
        win_valid_d = (win_mode_e'(mode) == MODE_SLIDING) || (phase_q == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q      <= '0;
      fill_q      <= '0;
      phase_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      taps_q      <= taps_d;
      fill_q      <= fill_d;
      phase_q     <= phase_d;
      win_valid_q <= win_valid_d;
    end
  end

  vld_delay #(
    .DEPTH(LAT)
  ) u_vld_delay (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .d  (win_valid_q),
    .q  (mean_valid)
  );

  assign tap_000   = taps_q[0];
  assign tap_001   = taps_q[1];
  assign tap_002   = taps_q[2];
  assign tap_003   = taps_q[3];
  assign tap_004   = taps_q[4];
  assign tap_005   = taps_q[5];
  assign tap_006   = taps_q[6];
  assign tap_007   = taps_q[7];
  assign win_valid = win_valid_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_mean8_window.sv
// Scoreboard bench for mean8_window: a queue-based window model predicts
// qualified windows; a monitor checks taps and mean_valid alignment.
module tb_mean8_window;
  import mean_pkg::*;

  localparam int WID = 16;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic [WID-1:0]  s_data;
  logic            mode;
  logic            flush;
  logic [WID-1:0]  tap_000, tap_001, tap_002, tap_003;
  logic [WID-1:0]  tap_004, tap_005, tap_006, tap_007;
  logic            win_valid;
  logic            mean_valid;
  logic [3:0]      fill;
  logic [8*WID-1:0] dut_taps;

  mean8_window #(.WID(WID), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
    .mode(mode), .flush(flush),
    .tap_000(tap_000), .tap_001(tap_001), .tap_002(tap_002), .tap_003(tap_003),
    .tap_004(tap_004), .tap_005(tap_005), .tap_006(tap_006), .tap_007(tap_007),
    .win_valid(win_valid), .mean_valid(mean_valid), .fill(fill)
  );

  assign dut_taps = {tap_007, tap_006, tap_005, tap_004,
                     tap_003, tap_002, tap_001, tap_000};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               cyc;
    logic [8*WID-1:0] taps;
    int               mean;
  } exp_t;

  exp_t win_q[$];
  exp_t mean_q[$];

  // Reference: index 0 newest; accepts counted since last flush/reset.
  logic [WID-1:0] m_win[8];
  int             m_fill;
  int             m_acc;
  logic           m_wv;
  int             hist[16];

  task automatic compare(input string name, input logic [8*WID-1:0] act,
                         input logic [8*WID-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8*WID-1:0] pack_model();
    logic [8*WID-1:0] r;
    for (int k = 0; k < 8; k++) r[k*WID +: WID] = m_win[k];
    return r;
  endfunction

  task automatic model_flush();
    for (int k = 0; k < 8; k++) m_win[k] = '0;
    m_fill = 0;
    m_acc  = 0;
    m_wv   = 1'b0;
    win_q.delete();
    mean_q.delete();
  endtask

  task automatic checkOutput();
    compare("fill", 128'(fill), 128'(m_fill));
    compare("win_valid", 128'(win_valid), 128'(m_wv));
    compare("taps", dut_taps, pack_model());
  endtask

  task automatic applyStimulus(input logic v, input logic [WID-1:0] d, input logic f);
    exp_t e;
    int   sum;
    s_valid = v;
    s_data  = d;
    flush   = f;
    @(posedge clk);
    #1;
    if (f) begin
      model_flush();
    end else if (v) begin
      for (int k = 7; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = d;
      m_fill   = (m_fill < 8) ? m_fill + 1 : 8;
      m_acc++;
      m_wv = (m_fill == 8) && (mode == 1'b0 || ((m_acc - 8) % 8) == 0);
      if (m_wv) begin
        sum = 0;
        for (int k = 0; k < 8; k++) sum += int'(m_win[k]);
        e.cyc  = cyc;
        e.taps = pack_model();
        e.mean = sum / 8;
        win_q.push_back(e);
        e.cyc = cyc + LAT;
        mean_q.push_back(e);
      end
    end else begin
      m_wv = 1'b0;
    end
    checkOutput();
  endtask

  // Monitor: mean8 is modelled as floor(sum/8) of the taps LAT cycles back.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    if (!rst) begin
      s = int'(tap_000) + int'(tap_001) + int'(tap_002) + int'(tap_003) +
          int'(tap_004) + int'(tap_005) + int'(tap_006) + int'(tap_007);
      hist[cyc % 16] = s;
      if (win_valid) begin
        if (win_q.size() == 0) begin
          compare("unexpected_win_valid", 128'(1), 128'(0));
        end else begin
          e = win_q.pop_front();
          compare("win_cycle", 128'(cyc), 128'(e.cyc));
          compare("win_taps", dut_taps, e.taps);
        end
      end
      if (mean_valid) begin
        if (mean_q.size() == 0) begin
          compare("unexpected_mean_valid", 128'(1), 128'(0));
        end else begin
          e = mean_q.pop_front();
          compare("mean_cycle", 128'(cyc), 128'(e.cyc));
          compare("o_mean", 128'(hist[((cyc - LAT) % 16 + 16) % 16] / 8), 128'(e.mean));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; mode = 1'b0; flush = 1'b0;
    model_flush();
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    compare("reset_mean_valid", 128'(mean_valid), 128'(0));
    rst = 1'b0;

    // Sliding ramp 1..8: single window, mean 4.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, WID'(i), 1'b0);
    // Flush two clocks after the window with a colliding sample.
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, WID'(99), 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0);

    // Continuous 1..16: nine windows, means 4..12.
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, WID'(i), 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0);

    // Block mode: 8 x FFFF then 8 x 2.
    mode = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'hFFFF, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h0002, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b0);

    // Gapped sliding: one accept every third cycle.
    mode = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, WID'($urandom), 1'b0);
      applyStimulus(1'b0, WID'($urandom), 1'b0);
      applyStimulus(1'b0, WID'($urandom), 1'b0);
    end

    // Async reset between edges with windows still in flight.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, WID'($urandom), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    compare("async_rst_taps", dut_taps, '0);
    compare("async_rst_fill", 128'(fill), 128'(0));
    compare("async_rst_win_valid", 128'(win_valid), 128'(0));
    compare("async_rst_mean_valid", 128'(mean_valid), 128'(0));
    model_flush();
    @(posedge clk);
    #1;
    checkOutput();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, WID'($urandom), 1'b0);

    // Randomised traffic with occasional flush and mode change.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        mode = 1'($urandom_range(0, 1));
        applyStimulus(1'($urandom_range(0, 1)), WID'($urandom), 1'b1);
      end else begin
        applyStimulus(1'($urandom_range(0, 2) != 0), WID'($urandom), 1'b0);
      end
    end

    for (int i = 0; i < LAT + 4; i++) applyStimulus(1'b0, '0, 1'b0);
    compare("win_queue_drained", 128'(win_q.size()), 128'(0));
    compare("mean_queue_drained", 128'(mean_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
